id_hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the ID stage. Detects load-use hazards between the

---
 rtl/id_hazard_ctrl_pkg.sv | 35 +++
 rtl/id_hazard_ctrl_load_use_detect.sv | 37 +++
 rtl/id_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_id_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared MIPS opcode/funct encodings, FSM state encoding and the ID-stage control bundle.
package id_hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_HALTED   = 2'd2,
    ST_STEP     = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1};

endpackage

// File: rtl/id_hazard_ctrl_load_use_detect.sv
// Combinational load-use detect: decodes which source registers the ID instruction reads
// and compares them with the destination of a load sitting in EX.
module id_hazard_ctrl_load_use_detect
  import id_hazard_ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  output logic        hazard
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rs;
  logic       uses_rt;
  logic       unused_fields;

  assign opcode        = instruction[31:26];
  assign rs            = instruction[25:21];
  assign rt            = instruction[20:16];
  assign funct         = instruction[5:0];
  assign unused_fields = ^instruction[15:6];

  // Shifts by immediate take their operand from rt, not rs.
  assign uses_rs = !((opcode == OP_J) || (opcode == OP_JAL) || (opcode == OP_LUI) ||
                     ((opcode == OP_RTYPE) &&
                      ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA))));

  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                   (opcode == OP_BNE) || (opcode == OP_SW);

  assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                  ((uses_rs && (rs == ex_rt)) || (uses_rt && (rt == ex_rt)));

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage sequencing: load-use stalls, taken-branch flush, debug halt/single-step, stall perf count.
// Control outputs are combinational on state and inputs; all outputs are held low while reset is low.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      i_instruction,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_branch_taken,
  input  logic             i_halt,
  input  logic             i_step,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_count
);

  localparam logic [1:0] LU_INIT = 2'(LOAD_USE_STALLS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       lu_cnt;
  logic [1:0]       lu_cnt_nxt;
  logic             step_q;
  logic             step_rise;
  logic             hazard;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] stall_count;

  id_hazard_ctrl_load_use_detect u_detect (
    .instruction (i_instruction),
    .ex_mem_read (i_ex_mem_read),
    .ex_rt       (i_ex_rt),
    .hazard      (hazard)
  );

  assign step_rise = i_step && !step_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_RUN;
      lu_cnt <= 2'd0;
      step_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
      step_q <= i_step;
    end
  end

  always_comb begin
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    ctrl       = CTRL_RUN;
    case (state)
      ST_RUN, ST_STEP: begin
        // A hazard beats a taken branch: the branch re-resolves once the load data is ready.
        // A step cycle executes even with halt still asserted.
        if (hazard)                              ctrl = CTRL_FREEZE;
        else if (i_branch_taken)                 ctrl = CTRL_FLUSH;
        else if (i_halt && (state == ST_RUN))    ctrl = CTRL_FREEZE;

        if (hazard && (LOAD_USE_STALLS > 1)) begin
          state_nxt  = ST_LU_STALL;
          lu_cnt_nxt = LU_INIT;
        end else if (state == ST_STEP) begin
          state_nxt = i_halt ? ST_HALTED : ST_RUN;
        end else if (!hazard && !i_branch_taken && i_halt) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_LU_STALL: begin
        ctrl       = CTRL_FREEZE;
        lu_cnt_nxt = lu_cnt - 2'd1;
        if (lu_cnt == 2'd1) state_nxt = i_halt ? ST_HALTED : ST_RUN;
      end
      ST_HALTED: begin
        ctrl = CTRL_FREEZE;
        if (!i_halt)        state_nxt = ST_RUN;
        else if (step_rise) state_nxt = ST_STEP;
      end
      default: state_nxt = ST_RUN;
    endcase
    if (!reset) ctrl = CTRL_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!ctrl.pc_write && (state != ST_HALTED) && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign o_pc_write     = ctrl.pc_write;
  assign o_if_id_write  = ctrl.if_id_write;
  assign o_if_id_flush  = ctrl.if_id_flush;
  assign o_id_ex_bubble = ctrl.id_ex_bubble;
  assign o_state        = state;
  assign o_stall_count  = stall_count;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench: three instances (1, 2 and 3 load-use bubbles; the last with a 2-bit counter).
module tb_id_hazard_ctrl;

  localparam logic [3:0] C_IDLE   = 4'b0000;
  localparam logic [3:0] C_RUN    = 4'b1100;
  localparam logic [3:0] C_FLUSH  = 4'b1110;
  localparam logic [3:0] C_FREEZE = 4'b0001;

  localparam logic [31:0] I_ADD = 32'h0022_1820;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mr;
  logic [4:0]  ex_rt;
  logic        br;
  logic        halt;
  logic        step;

  logic        pw1, iw1, fl1, bb1;
  logic        pw2, iw2, fl2, bb2;
  logic        pw3, iw3, fl3, bb3;
  logic [1:0]  st1, st2, st3;
  logic [31:0] cnt1, cnt2;
  logic [1:0]  cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.LOAD_USE_STALLS(1), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .i_instruction(instr), .i_ex_mem_read(mr), .i_ex_rt(ex_rt),
    .i_branch_taken(br), .i_halt(halt), .i_step(step),
    .o_pc_write(pw1), .o_if_id_write(iw1), .o_if_id_flush(fl1), .o_id_ex_bubble(bb1),
    .o_state(st1), .o_stall_count(cnt1));

  id_hazard_ctrl #(.LOAD_USE_STALLS(2), .CNT_W(32)) u2 (
    .clk(clk), .reset(reset), .i_instruction(instr), .i_ex_mem_read(mr), .i_ex_rt(ex_rt),
    .i_branch_taken(br), .i_halt(halt), .i_step(step),
    .o_pc_write(pw2), .o_if_id_write(iw2), .o_if_id_flush(fl2), .o_id_ex_bubble(bb2),
    .o_state(st2), .o_stall_count(cnt2));

  id_hazard_ctrl #(.LOAD_USE_STALLS(3), .CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .i_instruction(instr), .i_ex_mem_read(mr), .i_ex_rt(ex_rt),
    .i_branch_taken(br), .i_halt(halt), .i_step(step),
    .o_pc_write(pw3), .o_if_id_write(iw3), .o_if_id_flush(fl3), .o_id_ex_bubble(bb3),
    .o_state(st3), .o_stall_count(cnt3));

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  rt;
    logic        br;
    logic        halt;
    logic [3:0]  exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr = 32'h0; mr = 1'b0; ex_rt = 5'd0; br = 1'b0; halt = 1'b0; step = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int c;
    vecs[0]  = '{"add_rs_hit",  I_ADD,         1'b1, 5'd1, 1'b0, 1'b0, C_FREEZE};
    vecs[1]  = '{"add_rt_hit",  I_ADD,         1'b1, 5'd2, 1'b0, 1'b0, C_FREEZE};
    vecs[2]  = '{"ex_rt_zero",  I_ADD,         1'b1, 5'd0, 1'b0, 1'b0, C_RUN};
    vecs[3]  = '{"no_load",     I_ADD,         1'b0, 5'd1, 1'b0, 1'b0, C_RUN};
    vecs[4]  = '{"j_rs",        32'h0821_0000, 1'b1, 5'd1, 1'b0, 1'b0, C_RUN};
    vecs[5]  = '{"jal_rs",      32'h0C21_0000, 1'b1, 5'd1, 1'b0, 1'b0, C_RUN};
    vecs[6]  = '{"sll_rs",      32'h0022_1900, 1'b1, 5'd1, 1'b0, 1'b0, C_RUN};
    vecs[7]  = '{"sll_rt",      32'h0022_1900, 1'b1, 5'd2, 1'b0, 1'b0, C_FREEZE};
    vecs[8]  = '{"srl_rs",      32'h0022_1902, 1'b1, 5'd1, 1'b0, 1'b0, C_RUN};
    vecs[9]  = '{"sra_rs",      32'h0022_1903, 1'b1, 5'd1, 1'b0, 1'b0, C_RUN};
    vecs[10] = '{"jr_rs",       32'h0020_0008, 1'b1, 5'd1, 1'b0, 1'b0, C_FREEZE};
    vecs[11] = '{"sw_rt",       32'hAC41_0004, 1'b1, 5'd1, 1'b0, 1'b0, C_FREEZE};
    vecs[12] = '{"lw_rt",       32'h8C41_0000, 1'b1, 5'd1, 1'b0, 1'b0, C_RUN};
    vecs[13] = '{"lw_rs",       32'h8C41_0000, 1'b1, 5'd2, 1'b0, 1'b0, C_FREEZE};
    vecs[14] = '{"lui_rs",      32'h3C21_0005, 1'b1, 5'd1, 1'b0, 1'b0, C_RUN};
    vecs[15] = '{"beq_rt",      32'h1022_0003, 1'b1, 5'd2, 1'b0, 1'b0, C_FREEZE};
    vecs[16] = '{"bne_rs",      32'h1422_0003, 1'b1, 5'd1, 1'b0, 1'b0, C_FREEZE};
    vecs[17] = '{"addi_rt",     32'h2041_0005, 1'b1, 5'd1, 1'b0, 1'b0, C_RUN};
    vecs[18] = '{"br_flush",    I_ADD,         1'b1, 5'd5, 1'b1, 1'b0, C_FLUSH};
    vecs[19] = '{"br_vs_haz",   I_ADD,         1'b1, 5'd1, 1'b1, 1'b0, C_FREEZE};
    vecs[20] = '{"halt_run",    I_ADD,         1'b0, 5'd0, 1'b0, 1'b1, C_FREEZE};
    vecs[21] = '{"halt_vs_br",  I_ADD,         1'b0, 5'd0, 1'b1, 1'b1, C_FLUSH};

    idle();
    reset = 1'b0;
    tick();
    tick();
    check("rst_ctrl", {pw1, iw1, fl1, bb1}, C_IDLE);
    check("rst_state", st1, 2'd0);
    check("rst_count", cnt1, 32'd0);
    reset = 1'b1;
    #1;
    check("post_rst_ctrl", {pw1, iw1, fl1, bb1}, C_RUN);

    for (int i = 0; i < NV; i++) begin
      do_reset();
      instr = vecs[i].instr; mr = vecs[i].mr; ex_rt = vecs[i].rt;
      br = vecs[i].br; halt = vecs[i].halt;
      #1;
      check({vecs[i].name, "_u1"}, {pw1, iw1, fl1, bb1}, vecs[i].exp);
      check({vecs[i].name, "_u2"}, {pw2, iw2, fl2, bb2}, vecs[i].exp);
    end

    // Load-use with 1, 2 and 3 bubbles, then counter saturation on the 2-bit instance.
    do_reset(); idle();
    instr = I_ADD; mr = 1'b1; ex_rt = 5'd1;
    #1;
    check("lu1_freeze", {pw1, iw1, fl1, bb1}, C_FREEZE);
    tick();
    mr = 1'b0;
    #1;
    check("lu1_release", {pw1, iw1, fl1, bb1}, C_RUN);
    check("lu1_count", cnt1, 32'd1);
    check("lu2_state1", st2, 2'd1);
    check("lu2_hold", {pw2, iw2, fl2, bb2}, C_FREEZE);
    check("lu3_state1", st3, 2'd1);
    tick();
    check("lu2_state0", st2, 2'd0);
    check("lu2_release", {pw2, iw2, fl2, bb2}, C_RUN);
    check("lu2_count", cnt2, 32'd2);
    check("lu1_count_hold", cnt1, 32'd1);
    check("lu3_still", st3, 2'd1);
    tick();
    check("lu3_state0", st3, 2'd0);
    check("lu3_count", cnt3, 2'd3);
    mr = 1'b1;
    tick();
    mr = 1'b0;
    tick(); tick(); tick();
    check("sat_count", cnt3, 2'd3);
    check("lu2_count2", cnt2, 32'd4);
    check("lu1_count2", cnt1, 32'd2);

    // Debug halt, single step, step held high, step into a load-use hazard, release.
    do_reset(); idle();
    instr = I_ADD; halt = 1'b1;
    #1;
    check("halt_enter_ctrl", {pw1, iw1, fl1, bb1}, C_FREEZE);
    tick();
    check("halt_state", st1, 2'd2);
    c = cnt1;
    tick(); tick();
    check("halt_state_hold", st1, 2'd2);
    check("halt_ctrl_hold", {pw1, iw1, fl1, bb1}, C_FREEZE);
    check("halt_count_hold", cnt1, c);
    step = 1'b1;
    tick();
    check("step_state", st1, 2'd3);
    check("step_ctrl", {pw1, iw1, fl1, bb1}, C_RUN);
    tick();
    check("step_back", st1, 2'd2);
    tick();
    check("step_held", st1, 2'd2);
    check("step_count", cnt1, c);
    step = 1'b0;
    tick();
    step = 1'b1; mr = 1'b1; ex_rt = 5'd1;
    tick();
    check("step_haz_state", st2, 2'd3);
    check("step_haz_ctrl", {pw2, iw2, fl2, bb2}, C_FREEZE);
    tick();
    mr = 1'b0;
    #1;
    check("step_haz_lu", st2, 2'd1);
    check("step_haz_u1", st1, 2'd2);
    tick();
    check("step_lu_halted", st2, 2'd2);
    halt = 1'b0;
    tick();
    check("unhalt_state", st1, 2'd0);
    check("unhalt_ctrl", {pw1, iw1, fl1, bb1}, C_RUN);

    // Halt never shortens a load-use stall.
    do_reset(); idle();
    instr = I_ADD; mr = 1'b1; ex_rt = 5'd1; halt = 1'b1;
    #1;
    check("lu_halt_ctrl", {pw3, iw3, fl3, bb3}, C_FREEZE);
    tick();
    mr = 1'b0;
    #1;
    check("lu_halt_s1", st3, 2'd1);
    tick();
    check("lu_halt_s2", st3, 2'd1);
    tick();
    check("lu_halt_s3", st3, 2'd2);

    // Reset in the middle of a 3-bubble stall.
    do_reset(); idle();
    instr = I_ADD; mr = 1'b1; ex_rt = 5'd1;
    tick();
    mr = 1'b0;
    #1;
    check("mid_stall_state", st3, 2'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_ctrl", {pw3, iw3, fl3, bb3}, C_IDLE);
    tick();
    check("mid_rst_state", st3, 2'd0);
    check("mid_rst_count", cnt3, 2'd0);
    check("mid_rst_ctrl2", {pw3, iw3, fl3, bb3}, C_IDLE);
    reset = 1'b1;
    #1;
    check("mid_rst_release", {pw3, iw3, fl3, bb3}, C_RUN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
